// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg
//   Shared types for the ALU command queue: alu32 control encodings, the
//   queued command layout, the captured flag layout and the result FSM states.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_NOR = 3'b110,
        ALU_XOR = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  control;
    } cmd_t;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } res_state_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
//   Circular command buffer with occupancy count. DEPTH must be a power of
//   two (>= 2) so the pointers wrap by natural overflow.
//   Ports:
//     clock, reset         rising-edge clock, async active-low reset
//     push, wdata          write request / command word (ignored when full)
//     pop                  drop head entry (ignored when empty)
//     rdata                head entry (undefined content when empty)
//     count                current occupancy, 0..DEPTH
import alu_cmd_pkg::*;

module alu_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [CMD_W-1:0]           wdata,
    input  logic                       pop,
    output logic [CMD_W-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop  && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue
//   Buffers ALU commands, presents the head command to an external alu32,
//   and captures its result into a valid/ready output register.
//   Optional feature macro: ALU_CMD_STICKY_OVF_EN enables the sticky overflow
//   indicator; without it sticky_ovf is 0 and clr_sticky is ignored.
//   Ports:
//     clock, reset                         clock, async active-low reset
//     in_valid/in_ready, in_a/in_b/in_control   command input handshake
//     alu_a/alu_b/alu_control              head command to alu32 (0 when empty)
//     alu_out, alu_overflow/zero/negative  alu32 result and flags
//     res_valid/res_ready, res_out, res_flags   captured result handshake
//     count                                queue occupancy
//     sticky_ovf, clr_sticky               sticky overflow flag and its clear
import alu_cmd_pkg::*;

module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [2:0]                 in_control,
    output logic [31:0]                alu_a,
    output logic [31:0]                alu_b,
    output logic [2:0]                 alu_control,
    input  logic [31:0]                alu_out,
    input  logic                       alu_overflow,
    input  logic                       alu_zero,
    input  logic                       alu_negative,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [31:0]                res_out,
    output logic [2:0]                 res_flags,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sticky_ovf,
    input  logic                       clr_sticky
);

    localparam int CW = $clog2(DEPTH + 1);

    res_state_t state;
    res_state_t state_next;
    cmd_t       in_cmd;
    cmd_t       head;
    flags_t     flags_q;
    logic [CMD_W-1:0] head_raw;
    logic       push;
    logic       issue;

    // No push when full, even if an issue frees a slot this same cycle.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign issue    = (count != '0) && ((state == ST_EMPTY) || res_ready);

    assign in_cmd = '{a: in_a, b: in_b, control: in_control};
    assign head   = cmd_t'(head_raw);

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (in_cmd),
        .pop   (issue),
        .rdata (head_raw),
        .count (count)
    );

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        if (count != '0) begin
            alu_a       = head.a;
            alu_b       = head.b;
            alu_control = head.control;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        res_valid  = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (issue) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                res_valid = 1'b1;
                if (res_ready && !issue) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_out <= '0;
            flags_q <= '0;
        end else if (issue) begin
            res_out <= alu_out;
            flags_q <= '{overflow: alu_overflow, zero: alu_zero, negative: alu_negative};
        end
    end

    assign res_flags = flags_q;

`ifdef ALU_CMD_STICKY_OVF_EN
    // Set has priority over clear so an overflow in the clearing cycle is kept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky_ovf <= 1'b0;
        end else if (issue && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_ovf        = 1'b0;
`endif

endmodule
